// File: rtl/mult_div_pkg.sv
// mult_div_pkg: shared state encoding and operation codes for mult_div_seq.
//   md_state_t : controller states IDLE, LOAD, ITER, FIX, DONE
//   OP_DIV     : div_mult value selecting divide
//   OP_MUL     : div_mult value selecting multiply
package mult_div_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, ITER, FIX, DONE} md_state_t;
    localparam logic OP_DIV = 1'b0;
    localparam logic OP_MUL = 1'b1;
endpackage

// File: rtl/mult_div_ctrl.sv
// mult_div_ctrl: sequencing FSM and iteration counter for mult_div_seq.
//   clk     in  : clock, rising edge
//   reset_L in  : synchronous active-low reset
//   go      in  : start request, sampled in IDLE; DONE is held while high
//   early   in  : LOAD-time exit request (divide by zero or early overflow)
//   state   out : current FSM state, used by the datapath
//   busy    out : high in LOAD, ITER and FIX
//   done    out : high in DONE
module mult_div_ctrl import mult_div_pkg::*; #(
    parameter int N = 16
) (
    input  logic      clk,
    input  logic      reset_L,
    input  logic      go,
    input  logic      early,
    output md_state_t state,
    output logic      busy,
    output logic      done
);
    localparam int CW = $clog2(N) + 1;
    md_state_t nxt;
    logic [CW-1:0] cnt;
    // Counter runs only in ITER, so leaving LOAD always starts it at zero.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= nxt;
            cnt   <= (state == ITER) ? cnt + 1'b1 : '0;
        end
    end
    always_comb begin
        nxt  = state;
        busy = 1'b0;
        done = 1'b0;
        case (state)
            IDLE: nxt = go ? LOAD : IDLE;
            LOAD: begin
                busy = 1'b1;
                nxt  = early ? DONE : ITER;
            end
            ITER: begin
                busy = 1'b1;
                nxt  = (cnt == CW'(N - 1)) ? FIX : ITER;
            end
            FIX: begin
                busy = 1'b1;
                nxt  = DONE;
            end
            DONE: begin
                done = 1'b1;
                nxt  = go ? DONE : IDLE;
            end
            default: nxt = IDLE;
        endcase
    end
endmodule

// File: rtl/mult_div_seq.sv
// mult_div_seq: sequential signed multiplier (shift-add) / divider (restoring), one bit per cycle.
//   clk      in  : clock, rising edge
//   reset_L  in  : synchronous active-low reset
//   go       in  : start request, sampled in IDLE
//   div_mult in  : 0 = divide, 1 = multiply (latched with go)
//   ent_2n   in  : 2N-bit signed dividend; low N bits are the multiplicand
//   ent_n    in  : N-bit signed divisor or multiplier
//   sal      out : signed product, or quotient sign-extended to 2N
//   rem      out : signed remainder (0 for multiply)
//   done     out : result valid, held until go is low
//   busy     out : operation in progress
//   dz       out : divide by zero
//   ovf      out : quotient does not fit N signed bits
// Build option MULT_DIV_REM_EN: when defined the remainder register is built,
// otherwise rem is tied to 0.
module mult_div_seq import mult_div_pkg::*; #(
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           reset_L,
    input  logic           go,
    input  logic           div_mult,
    input  logic [2*N-1:0] ent_2n,
    input  logic [N-1:0]   ent_n,
    output logic [2*N-1:0] sal,
    output logic [N-1:0]   rem,
    output logic           done,
    output logic           busy,
    output logic           dz,
    output logic           ovf
);
    md_state_t state;
    logic           op;
    logic [2*N-1:0] a_q;
    logic [N-1:0]   b_q;
    logic           neg;
    logic [N-1:0]   mag_d;
    // acc holds {partial (N+1 bits), low word (N bits)}: for multiply the low
    // word is the multiplier being consumed, for divide the quotient being built.
    logic [2*N:0]   acc;
    logic           mul, a_sign, early_dz, early_ovf, early, ge, late_ovf;
    logic [2*N-1:0] a_ext, mag_a, prod, q_ext, fix_sal;
    logic [N-1:0]   mag_b, q_mag;
    logic [N:0]     mul_sum;
    logic [2*N:0]   mul_next, shl, div_next;

    mult_div_ctrl #(.N(N)) u_ctrl (
        .clk     (clk),
        .reset_L (reset_L),
        .go      (go),
        .early   (early),
        .state   (state),
        .busy    (busy),
        .done    (done)
    );

    always_comb begin
        mul       = (op == OP_MUL);
        a_sign    = mul ? a_q[N-1] : a_q[2*N-1];
        a_ext     = mul ? {{N{a_q[N-1]}}, a_q[N-1:0]} : a_q;
        mag_a     = a_sign ? -a_ext : a_ext;
        mag_b     = b_q[N-1] ? -b_q : b_q;
        early_dz  = !mul && (b_q == '0);
        // Upper half of the dividend magnitude not below the divisor means the
        // quotient cannot fit in N bits at all.
        early_ovf = !mul && (mag_a[2*N-1:N] >= mag_b);
        early     = early_dz || early_ovf;
        mul_sum   = acc[2*N:N] + (acc[0] ? {1'b0, mag_d} : '0);
        mul_next  = {1'b0, mul_sum, acc[N-1:1]};
        shl       = {acc[2*N-1:0], 1'b0};
        ge        = shl[2*N:N] >= {1'b0, mag_d};
        div_next  = ge ? {shl[2*N:N] - {1'b0, mag_d}, shl[N-1:1], 1'b1} : shl;
        prod      = acc[2*N-1:0];
        q_mag     = acc[N-1:0];
        q_ext     = {{N{1'b0}}, q_mag};
        // A negative quotient may reach magnitude 2^(N-1); a positive one may not.
        late_ovf  = neg ? (q_mag > {1'b1, {(N-1){1'b0}}}) : q_mag[N-1];
        fix_sal   = mul ? (neg ? -prod : prod) : (late_ovf ? '0 : (neg ? -q_ext : q_ext));
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            op    <= OP_DIV;
            a_q   <= '0;
            b_q   <= '0;
            neg   <= 1'b0;
            mag_d <= '0;
            acc   <= '0;
            sal   <= '0;
            dz    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (go) begin
                    op  <= div_mult;
                    a_q <= ent_2n;
                    b_q <= ent_n;
                end
                LOAD: begin
                    neg   <= a_sign ^ b_q[N-1];
                    mag_d <= mul ? mag_a[N-1:0] : mag_b;
                    acc   <= mul ? {{(N+1){1'b0}}, mag_b} : {1'b0, mag_a};
                    if (early) begin
                        sal <= '0;
                        dz  <= early_dz;
                        ovf <= !early_dz;
                    end
                end
                ITER: acc <= mul ? mul_next : div_next;
                FIX: begin
                    sal <= fix_sal;
                    dz  <= 1'b0;
                    ovf <= !mul && late_ovf;
                end
                default: ;
            endcase
        end
    end

`ifdef MULT_DIV_REM_EN
    logic         sa;
    logic [N-1:0] r_mag;
    assign r_mag = acc[2*N-1:N];
    // Remainder follows the dividend sign.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            sa  <= 1'b0;
            rem <= '0;
        end else begin
            sa  <= (state == LOAD) ? a_sign : sa;
            rem <= (state == LOAD && early) ? '0 :
                   (state == FIX) ? (mul ? '0 : (sa ? -r_mag : r_mag)) : rem;
        end
    end
`else
    assign rem = '0;
`endif
endmodule

// File: tb/tb_mult_div_seq.sv
// tb_mult_div_seq: directed self-checking bench for mult_div_seq with N=16.
module tb_mult_div_seq;
    logic        clk = 1'b0;
    logic        reset_L, go, div_mult;
    logic [31:0] ent_2n;
    logic [15:0] ent_n;
    logic [31:0] sal;
    logic [15:0] rem;
    logic        done, busy, dz, ovf;
    int          npass = 0;
    int          ntot = 0;
    int          lat;

    mult_div_seq #(.N(16)) dut (
        .clk      (clk),
        .reset_L  (reset_L),
        .go       (go),
        .div_mult (div_mult),
        .ent_2n   (ent_2n),
        .ent_n    (ent_n),
        .sal      (sal),
        .rem      (rem),
        .done     (done),
        .busy     (busy),
        .dz       (dz),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntot++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else npass++;
    endtask

    // Start an operation, scramble the inputs after the sampling edge and
    // return the number of edges from the go-sampling edge to done (-1 on timeout).
    task automatic op_run(input logic op, input logic [31:0] a, input logic [15:0] b, output int l);
        @(negedge clk);
        go = 1'b1; div_mult = op; ent_2n = a; ent_n = b;
        l = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) begin
                chk("busy_after_go", {31'b0, busy}, 32'd1);
                ent_2n = ~a; ent_n = ~b; div_mult = ~op;
            end
            if (done) begin
                l = i;
                break;
            end
        end
    endtask

    task automatic release_go(input string tag, input int hold);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_done"}, {31'b0, done}, 32'd1);
            chk({tag, "_hold_busy"}, {31'b0, busy}, 32'd0);
        end
        go = 1'b0;
        @(negedge clk);
        chk({tag, "_done_fall"}, {31'b0, done}, 32'd0);
    endtask

    task automatic chk_res(input string tag, input logic [31:0] s, input logic [15:0] r,
                           input logic d, input logic o, input int l);
        chk({tag, "_lat"}, 32'(lat), 32'(l));
        chk({tag, "_sal"}, sal, s);
        chk({tag, "_rem"}, {16'b0, rem}, {16'b0, r});
        chk({tag, "_dz"}, {31'b0, dz}, {31'b0, d});
        chk({tag, "_ovf"}, {31'b0, ovf}, {31'b0, o});
    endtask

    initial begin
        logic [15:0] r_pos2, r_neg2;
`ifdef MULT_DIV_REM_EN
        r_pos2 = 16'h0002; r_neg2 = 16'hFFFE;
`else
        r_pos2 = 16'h0000; r_neg2 = 16'h0000;
`endif
        reset_L = 1'b0; go = 1'b1; div_mult = 1'b1; ent_2n = 32'h5; ent_n = 16'h3;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_sal", sal, 32'd0);
        chk("rst_flags", {30'b0, dz, ovf}, 32'd0);
        go = 1'b0; reset_L = 1'b1;
        @(negedge clk);

        op_run(1'b1, 32'h0000FFFD, 16'd7, lat);
        chk_res("mul_m3x7", 32'hFFFFFFEB, 16'h0, 1'b0, 1'b0, 18);
        release_go("mul_m3x7", 3);

        op_run(1'b1, 32'h00008000, 16'h8000, lat);
        chk_res("mul_min2", 32'h40000000, 16'h0, 1'b0, 1'b0, 18);
        release_go("mul_min2", 0);

        op_run(1'b0, 32'd100, 16'hFFF9, lat);
        chk_res("div_100_m7", 32'hFFFFFFF2, r_pos2, 1'b0, 1'b0, 18);
        release_go("div_100_m7", 0);

        op_run(1'b0, 32'h00001234, 16'h0000, lat);
        chk_res("div_zero", 32'h0, 16'h0, 1'b1, 1'b0, 1);
        release_go("div_zero", 0);

        op_run(1'b0, 32'h00010000, 16'd1, lat);
        chk_res("div_ovf_early", 32'h0, 16'h0, 1'b0, 1'b1, 1);
        release_go("div_ovf_early", 0);

        op_run(1'b0, 32'hFFFF8000, 16'd1, lat);
        chk_res("div_negmin", 32'hFFFF8000, 16'h0, 1'b0, 1'b0, 18);
        release_go("div_negmin", 0);

        op_run(1'b0, 32'h00008000, 16'd1, lat);
        chk_res("div_ovf_late", 32'h0, 16'h0, 1'b0, 1'b1, 18);
        release_go("div_ovf_late", 0);

        op_run(1'b0, 32'hFFFFFF9C, 16'd7, lat);
        chk_res("div_m100_7", 32'hFFFFFFF2, r_neg2, 1'b0, 1'b0, 18);
        release_go("div_m100_7", 0);

        op_run(1'b1, 32'h00007FFF, 16'h7FFF, lat);
        chk_res("mul_max2", 32'h3FFF0001, 16'h0, 1'b0, 1'b0, 18);
        release_go("mul_max2", 0);

        // Reset in the middle of ITER abandons the operation.
        @(negedge clk);
        go = 1'b1; div_mult = 1'b1; ent_2n = 32'h0000FFFD; ent_n = 16'd7;
        @(negedge clk);
        go = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_busy", {31'b0, busy}, 32'd1);
        reset_L = 1'b0;
        @(negedge clk);
        chk("midrst_sal", sal, 32'd0);
        chk("midrst_rem", {16'b0, rem}, 32'd0);
        chk("midrst_ctl", {28'b0, done, busy, dz, ovf}, 32'd0);
        reset_L = 1'b1;
        repeat (20) @(negedge clk);
        chk("midrst_idle", {30'b0, done, busy}, 32'd0);
        chk("midrst_nores", sal, 32'd0);

        op_run(1'b0, 32'hFFFFFF9C, 16'hFFF9, lat);
        chk_res("div_m100_m7", 32'h0000000E, r_neg2, 1'b0, 1'b0, 18);
        release_go("div_m100_m7", 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule

// File: doc/mult_div_seq.md
# mult_div_seq

Clocked, parametrised signed multiplier/divider that replaces the behavioural multiply/divide model with synthesizable RTL. Multiplication uses iterative shift-add and division uses restoring shift-subtract, each one bit per cycle, under a go/done handshake. Unlike its predecessor, the block adds a configurable width, a registered remainder, and divide-by-zero and quotient-overflow flags. It sits beside the microprogrammed divider datapath as its arithmetic unit.

## Interface
- `N`, default 16: operand width. Wide input and result are 2N; minimum 4.
- `clk` in 1: single clock, rising edge.
- `reset_L` in 1: synchronous, active-low reset.
- `go` in 1: start request, level-sensitive; sampled only in IDLE.
- `div_mult` in 1: operation select, 0 = divide, 1 = multiply; latched with `go`.
- `ent_2n` in 2N: signed dividend. For multiply, only `ent_2n[N-1:0]` is used, as a signed multiplicand.
- `ent_n` in N: signed divisor or multiplier.
- `sal` out 2N: signed product, or quotient sign-extended to 2N.
- `rem` out N: signed remainder; 0 for multiply.
- `done` out 1: result valid; held until `go` is low.
- `busy` out 1: high in LOAD, ITER and FIX.
- `dz` out 1: divide by zero.
- `ovf` out 1: quotient not representable in N signed bits.

## Operation
- FSM states: IDLE, LOAD, ITER, FIX, DONE.
- **IDLE:**
  - If `go`=1, latch `div_mult`, `ent_2n` and `ent_n`; go to LOAD.
  - Otherwise stay in IDLE.
- **LOAD:**
  - Record the operand signs and convert both operands to magnitudes.
  - Clear the counter and the accumulator.
  - Divide with `ent_n`=0: set `dz`=1, `sal`=0, `rem`=0; go directly to DONE.
  - Divide with |dividend[2N-1:N]| ≥ |divisor|: set `ovf`=1, `sal`=0, `rem`=0; go directly to DONE.
  - Otherwise go to ITER.
- **ITER:** exactly N cycles.
  - Multiply: add the shifted multiplicand when the current multiplier bit is 1, then shift right.
  - Divide: shift left, trial-subtract the divisor from the upper N bits, restore if the result is negative, and shift in the quotient bit.
- **FIX:**
  - Product sign = XOR of the operand signs.
  - Quotient sign = XOR of the operand signs; the quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - Late overflow:
    - quotient positive and magnitude ≥ 2^(N-1) → `ovf`=1, `sal`=0;
    - quotient negative and magnitude > 2^(N-1) → `ovf`=1, `sal`=0.
  - Go to DONE.
- **DONE:**
  - `done`=1. `sal`, `rem`, `dz` and `ovf` are all updated on the edge that enters DONE.
  - Stay in DONE while `go`=1; go to IDLE on the first edge with `go`=0.
- A `go` held high never retriggers; a new operation requires a low-to-high cycle on `go`.
- Input changes after the `go`-sampling edge have no effect.
- Result outputs hold their value from the entry to DONE until the next entry to DONE.
- `dz` and `ovf` are both 0 for multiply and for valid divides.

## Timing
- Call the edge where `go` is sampled in IDLE edge 0.
- Normal path: LOAD at edge 1, ITER on edges 2..N+1, FIX at edge N+2. `done` is high after edge N+2, i.e. latency is N+2 cycles (18 for N=16).
- Early exit (`dz`, or `ovf` from LOAD): `done` is high after edge 1 (latency 1).
- `done` falls on the edge after `go` is sampled low.
- `busy` is high from after edge 0 until the edge that enters DONE.
- Reset (`reset_L`=0 at an edge), from any state including mid-ITER:
  - state → IDLE;
  - `sal`, `rem`, `done`, `busy`, `dz` and `ovf` all → 0;
  - the counter clears;
  - the operation is abandoned, with no partial result.
- `reset_L` takes priority over `go` in the same cycle.

## Configuration
- Macro: `MULT_DIV_REM_EN`.
- Defined: the remainder register is built and `rem` carries the signed remainder as specified.
- Undefined: no remainder register is built. `rem` is tied to 0, and the restore step writes only the working partial-remainder needed by the algorithm.
- Quotient, flags and timing are identical in both cases.

## Structure
- Package `mult_div_pkg` holds:
  - the state enum `md_state_t` (IDLE, LOAD, ITER, FIX, DONE);
  - op constants `OP_DIV`=1'b0 and `OP_MUL`=1'b1.
- Sub-module `mult_div_ctrl`: contains the FSM, the iteration counter (width $clog2(N)+1) and the `busy`/`done` generation.
- The datapath (magnitudes, accumulator, sign fix-up) stays in `mult_div_seq`.

## Test plan
All cases use N=16.
- Multiply, `ent_2n[15:0]`=0xFFFD (-3), `ent_n`=7 → `sal`=0xFFFFFFEB, `rem`=0, `done` high after 18 cycles.
- Multiply, both operands 0x8000 (-32768) → `sal`=0x40000000, `ovf`=0.
- Divide 100 by `ent_n`=0xFFF9 (-7) → `sal`=0xFFFFFFF2 (-14), `rem`=2 with `MULT_DIV_REM_EN`, `rem`=0 without it.
- Divide by 0 → `dz`=1, `sal`=0, `done` after 1 cycle. Then divide 0x00010000 by 1 → `ovf`=1, `sal`=0.
- Divide 0xFFFF8000 by 1 → `sal`=0xFFFF8000, `ovf`=0. Divide 0x00008000 by 1 → `ovf`=1.
- Reset pulse at ITER cycle 5 → all outputs 0 next edge. Holding `go` high through DONE → no second start; `done` drops one cycle after `go` falls.
